// File: rtl/cpu_control_sequencer_if.sv
// Control bundle between the sequencer and the accumulator datapath.
// master = sequencer side, slave = datapath side.
interface cpu_control_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) ();
    logic              start;
    logic [DATA_W-1:0] ir;
    logic              pc_clr;
    logic              pc_inc;
    logic              ar_ld_pc;
    logic              ar_ld_ir;
    logic              ar_ld_dr;
    logic              ir_ld;
    logic              mem_rd;
    logic              mem_wr;
    logic              alu_en;
    logic [2:0]        alu_op;
    logic              ac_ld;
    logic              ac_src;
    logic              busy;
    logic              halted;
    logic [3:0]        state;
    logic [CNT_W-1:0]  instr_cnt;

    modport master (
        input  start,
        input  ir,
        output pc_clr,
        output pc_inc,
        output ar_ld_pc,
        output ar_ld_ir,
        output ar_ld_dr,
        output ir_ld,
        output mem_rd,
        output mem_wr,
        output alu_en,
        output alu_op,
        output ac_ld,
        output ac_src,
        output busy,
        output halted,
        output state,
        output instr_cnt
    );

    modport slave (
        output start,
        output ir,
        input  pc_clr,
        input  pc_inc,
        input  ar_ld_pc,
        input  ar_ld_ir,
        input  ar_ld_dr,
        input  ir_ld,
        input  mem_rd,
        input  mem_wr,
        input  alu_en,
        input  alu_op,
        input  ac_ld,
        input  ac_src,
        input  busy,
        input  halted,
        input  state,
        input  instr_cnt
    );
endinterface

// File: rtl/cpu_control_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Strobes are registered: each edge loads the outputs of the state entered.
module cpu_control_sequencer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input logic                     CLK,
    input logic                     RST_N,
    cpu_control_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        CLR  = 4'd1,
        F0   = 4'd2,
        F1   = 4'd3,
        F2   = 4'd4,
        DEC  = 4'd5,
        IND0 = 4'd6,
        IND1 = 4'd7,
        E0   = 4'd8,
        E1   = 4'd9,
        HALT = 4'd10
    } state_t;

    typedef struct packed {
        logic       pc_clr;
        logic       pc_inc;
        logic       ar_ld_pc;
        logic       ar_ld_ir;
        logic       ar_ld_dr;
        logic       ir_ld;
        logic       mem_rd;
        logic       mem_wr;
        logic       alu_en;
        logic [2:0] alu_op;
        logic       ac_ld;
        logic       ac_src;
    } ctl_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b011;
    localparam logic [2:0] OP_LDA = 3'b100;
    localparam logic [2:0] OP_STA = 3'b101;
    localparam logic [2:0] OP_CMA = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    function automatic logic [2:0] opc(input logic [DATA_W-1:0] i);
        return i[ADDR_W+2:ADDR_W];
    endfunction

    function automatic logic is_mem(input logic [2:0] op);
        return op inside {OP_ADD, OP_SUB, OP_XOR, OP_LDA, OP_STA};
    endfunction

    // Opcodes that need a data read in E0 and finish in E1.
    function automatic logic is_rd(input logic [2:0] op);
        return op inside {OP_ADD, OP_SUB, OP_XOR, OP_LDA};
    endfunction

    function automatic state_t f_next(
        input state_t            s,
        input logic              st,
        input logic [DATA_W-1:0] i
    );
        logic [2:0] op;
        state_t     n;
        op = opc(i);
        n  = IDLE;
        unique case (s)
            IDLE: n = st ? CLR : IDLE;
            CLR:  n = F0;
            F0:   n = F1;
            F1:   n = F2;
            F2:   n = DEC;
            DEC: begin
                if (op == OP_HLT)
                    n = HALT;
                else if (i[DATA_W-1] && is_mem(op))
                    n = IND0;
                else
                    n = E0;
            end
            IND0: n = IND1;
            IND1: n = E0;
            E0:   n = is_rd(op) ? E1 : F0;
            E1:   n = F0;
            HALT: n = st ? F0 : HALT;
            default: n = IDLE;
        endcase
        return n;
    endfunction

    function automatic ctl_t f_ctl(
        input state_t            s,
        input logic [DATA_W-1:0] i
    );
        logic [2:0] op;
        ctl_t       c;
        op = opc(i);
        c  = '0;
        unique case (s)
            CLR:  c.pc_clr   = 1'b1;
            F0:   c.ar_ld_pc = 1'b1;
            F1: begin
                c.mem_rd = 1'b1;
                c.pc_inc = 1'b1;
            end
            F2:   c.ir_ld    = 1'b1;
            DEC:  c.ar_ld_ir = 1'b1;
            IND0: c.mem_rd   = 1'b1;
            IND1: c.ar_ld_dr = 1'b1;
            E0: begin
                if (is_rd(op)) begin
                    c.mem_rd = 1'b1;
                end else if (op == OP_STA) begin
                    c.mem_wr = 1'b1;
                end else if (op == OP_SHL || op == OP_CMA) begin
                    c.alu_en = 1'b1;
                    c.alu_op = op;
                    c.ac_ld  = 1'b1;
                end
            end
            E1: begin
                if (op == OP_LDA) begin
                    c.ac_ld  = 1'b1;
                    c.ac_src = 1'b1;
                end else if (is_rd(op)) begin
                    c.alu_en = 1'b1;
                    c.alu_op = op;
                    c.ac_ld  = 1'b1;
                end
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t           cur;
    state_t           nxt;
    ctl_t             ctl;
    logic             busy_q;
    logic             halt_q;
    logic [CNT_W-1:0] cnt;
    logic             retire;

    assign nxt = f_next(cur, bus.start, bus.ir);

    assign retire = ((cur == E0 || cur == E1) && nxt == F0)
                  || (cur == DEC && nxt == HALT);

    // State, registered strobes, status flags and retire counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cur    <= IDLE;
            ctl    <= '0;
            busy_q <= 1'b0;
            halt_q <= 1'b0;
            cnt    <= '0;
        end else begin
            cur    <= nxt;
            ctl    <= f_ctl(nxt, bus.ir);
            busy_q <= (nxt != IDLE) && (nxt != HALT);
            halt_q <= (nxt == HALT);
            if (retire)
                cnt <= cnt + 1'b1;
        end
    end

    assign bus.pc_clr    = ctl.pc_clr;
    assign bus.pc_inc    = ctl.pc_inc;
    assign bus.ar_ld_pc  = ctl.ar_ld_pc;
    assign bus.ar_ld_ir  = ctl.ar_ld_ir;
    assign bus.ar_ld_dr  = ctl.ar_ld_dr;
    assign bus.ir_ld     = ctl.ir_ld;
    assign bus.mem_rd    = ctl.mem_rd;
    assign bus.mem_wr    = ctl.mem_wr;
    assign bus.alu_en    = ctl.alu_en;
    assign bus.alu_op    = ctl.alu_op;
    assign bus.ac_ld     = ctl.ac_ld;
    assign bus.ac_src    = ctl.ac_src;
    assign bus.busy      = busy_q;
    assign bus.halted    = halt_q;
    assign bus.state     = cur;
    assign bus.instr_cnt = cnt;

    // AR has a single write port; two load sources at once is a bug.
    a_ar_onehot: assert property (@(posedge CLK) disable iff (!RST_N)
        $onehot0({ctl.ar_ld_pc, ctl.ar_ld_ir, ctl.ar_ld_dr}));

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Bench for cpu_control_sequencer: directed and random instruction streams
// checked against a per-instruction cycle table built from the opcode rules.
module tb_cpu_control_sequencer;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    logic [15:0] mcnt = '0;

    cpu_control_sequencer_if #(.DATA_W(8), .CNT_W(16)) bus ();
    cpu_control_sequencer_if #(.DATA_W(8), .CNT_W(3))  bus2 ();

    cpu_control_sequencer #(.ADDR_W(4), .DATA_W(8), .CNT_W(16)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    cpu_control_sequencer #(.ADDR_W(4), .DATA_W(8), .CNT_W(3)) dut2 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus2)
    );

    always #5 CLK = ~CLK;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_CLR  = 4'd1;
    localparam logic [3:0] S_F0   = 4'd2;
    localparam logic [3:0] S_F1   = 4'd3;
    localparam logic [3:0] S_F2   = 4'd4;
    localparam logic [3:0] S_DEC  = 4'd5;
    localparam logic [3:0] S_IND0 = 4'd6;
    localparam logic [3:0] S_IND1 = 4'd7;
    localparam logic [3:0] S_E0   = 4'd8;
    localparam logic [3:0] S_E1   = 4'd9;
    localparam logic [3:0] S_HALT = 4'd10;

    // {pc_clr,pc_inc,ar_ld_pc,ar_ld_ir,ar_ld_dr,ir_ld,mem_rd,mem_wr,alu_en}
    localparam logic [8:0] P_NONE = 9'h000;
    localparam logic [8:0] P_CLR  = 9'h100;
    localparam logic [8:0] P_INC  = 9'h080;
    localparam logic [8:0] P_ARPC = 9'h040;
    localparam logic [8:0] P_ARIR = 9'h020;
    localparam logic [8:0] P_ARDR = 9'h010;
    localparam logic [8:0] P_IRLD = 9'h008;
    localparam logic [8:0] P_RD   = 9'h004;
    localparam logic [8:0] P_WR   = 9'h002;
    localparam logic [8:0] P_ALU  = 9'h001;

    logic [8:0] strb;
    assign strb = {bus.pc_clr, bus.pc_inc, bus.ar_ld_pc, bus.ar_ld_ir,
                   bus.ar_ld_dr, bus.ir_ld, bus.mem_rd, bus.mem_wr,
                   bus.alu_en};

    typedef struct packed {
        logic [3:0] st;
        logic [8:0] strb;
        logic [2:0] op;
        logic       ld;
        logic       src;
    } exp_t;

    exp_t q[$];

    function automatic exp_t mk(input logic [3:0] st, input logic [8:0] s,
                                input logic [2:0] op, input logic ld,
                                input logic src);
        exp_t e;
        e.st = st; e.strb = s; e.op = op; e.ld = ld; e.src = src;
        return e;
    endfunction

    // Instruction latency from F0 through the last cycle.
    function automatic int lat(input logic [7:0] w);
        logic [2:0] op;
        op = w[6:4];
        if (op == 3'd7) return 4;
        if (op == 3'd3 || op == 3'd6) return 5;
        if (op == 3'd5) return w[7] ? 7 : 5;
        return w[7] ? 8 : 6;
    endfunction

    task automatic build(input logic [7:0] w);
        logic [2:0] op;
        logic       ind;
        op  = w[6:4];
        ind = w[7] && (op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        q.delete();
        q.push_back(mk(S_F0,  P_ARPC,        3'd0, 1'b0, 1'b0));
        q.push_back(mk(S_F1,  P_RD | P_INC,  3'd0, 1'b0, 1'b0));
        q.push_back(mk(S_F2,  P_IRLD,        3'd0, 1'b0, 1'b0));
        q.push_back(mk(S_DEC, P_ARIR,        3'd0, 1'b0, 1'b0));
        if (op != 3'd7) begin
            if (ind) begin
                q.push_back(mk(S_IND0, P_RD,   3'd0, 1'b0, 1'b0));
                q.push_back(mk(S_IND1, P_ARDR, 3'd0, 1'b0, 1'b0));
            end
            case (op)
                3'd0, 3'd1, 3'd2: begin
                    q.push_back(mk(S_E0, P_RD,  3'd0, 1'b0, 1'b0));
                    q.push_back(mk(S_E1, P_ALU, op,   1'b1, 1'b0));
                end
                3'd4: begin
                    q.push_back(mk(S_E0, P_RD,   3'd0, 1'b0, 1'b0));
                    q.push_back(mk(S_E1, P_NONE, 3'd0, 1'b1, 1'b1));
                end
                3'd5: q.push_back(mk(S_E0, P_WR, 3'd0, 1'b0, 1'b0));
                default: q.push_back(mk(S_E0, P_ALU, op, 1'b1, 1'b0));
            endcase
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Runs one instruction from F0; noisy toggles start while busy.
    task automatic run_instr(input logic [7:0] w, input bit noisy);
        int   n;
        exp_t e;
        logic [3:0] want_end;
        build(w);
        want_end = (w[6:4] == 3'd7) ? S_HALT : S_F0;
        n = 0;
        do begin
            if (n < q.size()) begin
                e = q[n];
                checks++;
                if (bus.state !== e.st || strb !== e.strb ||
                    bus.alu_op !== e.op || bus.ac_ld !== e.ld ||
                    bus.ac_src !== e.src || bus.busy !== 1'b1 ||
                    bus.halted !== 1'b0) begin
                    failures++;
                    $display("FAIL cycle ir=%02h n=%0d: got st=%0d s=%09b op=%0d ld=%b src=%b busy=%b hlt=%b want st=%0d s=%09b op=%0d ld=%b src=%b busy=1 hlt=0",
                             w, n, bus.state, strb, bus.alu_op, bus.ac_ld,
                             bus.ac_src, bus.busy, bus.halted, e.st, e.strb,
                             e.op, e.ld, e.src);
                end
            end
            if (n == 2) bus.ir = w;
            bus.start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            n++;
        end while (bus.state !== S_F0 && bus.state !== S_HALT && n < 20);
        bus.start = 1'b0;
        mcnt++;
        checks++;
        if (n != lat(w)) begin
            failures++;
            $display("FAIL latency ir=%02h: got %0d want %0d", w, n, lat(w));
        end
        checks++;
        if (bus.state !== want_end) begin
            failures++;
            $display("FAIL end_state ir=%02h: got %0d want %0d",
                     w, bus.state, want_end);
        end
        checks++;
        if (bus.instr_cnt !== mcnt) begin
            failures++;
            $display("FAIL instr_cnt ir=%02h: got %0d want %0d",
                     w, bus.instr_cnt, mcnt);
        end
    endtask

    task automatic resume_halt();
        checks++;
        if (bus.halted !== 1'b1 || bus.busy !== 1'b0 || strb !== P_NONE ||
            bus.ac_ld !== 1'b0) begin
            failures++;
            $display("FAIL halt_outputs: got hlt=%b busy=%b s=%09b want hlt=1 busy=0 s=0",
                     bus.halted, bus.busy, strb);
        end
        step();
        checks++;
        if (bus.state !== S_HALT) begin
            failures++;
            $display("FAIL halt_hold: got st=%0d want %0d", bus.state, S_HALT);
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++;
        if (bus.state !== S_F0 || strb !== P_ARPC || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL resume: got st=%0d s=%09b busy=%b want st=%0d s=%09b busy=1",
                     bus.state, strb, bus.busy, S_F0, P_ARPC);
        end
    endtask

    task automatic test_reset();
        RST_N      = 1'b0;
        bus.start  = 1'b0;
        bus.ir     = 8'h00;
        bus2.start = 1'b0;
        bus2.ir    = 8'h00;
        repeat (2) step();
        checks++;
        if (bus.state !== S_IDLE || strb !== P_NONE || bus.alu_op !== 3'd0 ||
            bus.ac_ld !== 1'b0 || bus.ac_src !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got st=%0d s=%09b op=%0d want all 0",
                     bus.state, strb, bus.alu_op);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.halted !== 1'b0 ||
            bus.instr_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_status: got busy=%b hlt=%b cnt=%0d want 0 0 0",
                     bus.busy, bus.halted, bus.instr_cnt);
        end
        RST_N = 1'b1;
        mcnt  = '0;
        repeat (3) step();
        checks++;
        if (bus.state !== S_IDLE || strb !== P_NONE || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold: got st=%0d s=%09b busy=%b want IDLE",
                     bus.state, strb, bus.busy);
        end
    endtask

    task automatic test_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++;
        if (bus.state !== S_CLR || strb !== P_CLR || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL clr_state: got st=%0d s=%09b busy=%b want st=1 s=%09b busy=1",
                     bus.state, strb, bus.busy, P_CLR);
        end
        step();
        checks++;
        if (bus.state !== S_F0 || strb !== P_ARPC || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL first_fetch: got st=%0d s=%09b want st=2 s=%09b",
                     bus.state, strb, P_ARPC);
        end
    endtask

    task automatic test_directed();
        logic [7:0] prog [9];
        prog = '{8'h03, 8'h85, 8'h52, 8'h60, 8'hE0,
                 8'h44, 8'hC3, 8'hD1, 8'h70};
        foreach (prog[k]) begin
            run_instr(prog[k], 1'b0);
            if (prog[k][6:4] == 3'd7) resume_halt();
        end
    endtask

    task automatic test_random();
        logic [7:0] w;
        for (int k = 0; k < 40; k++) begin
            w = 8'($urandom);
            run_instr(w, 1'b1);
            if (w[6:4] == 3'd7) resume_halt();
        end
    endtask

    task automatic test_reset_mid();
        step();
        step();
        bus.ir = 8'h4A;
        step();
        step();
        step();
        checks++;
        if (bus.state !== S_E1 || bus.ac_ld !== 1'b1 || bus.ac_src !== 1'b1) begin
            failures++;
            $display("FAIL lda_e1: got st=%0d ld=%b src=%b want st=9 ld=1 src=1",
                     bus.state, bus.ac_ld, bus.ac_src);
        end
        #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if (bus.state !== S_IDLE || strb !== P_NONE || bus.ac_ld !== 1'b0 ||
            bus.ac_src !== 1'b0 || bus.busy !== 1'b0 ||
            bus.instr_cnt !== 16'd0) begin
            failures++;
            $display("FAIL async_reset: got st=%0d s=%09b ld=%b busy=%b cnt=%0d want all 0",
                     bus.state, strb, bus.ac_ld, bus.busy, bus.instr_cnt);
        end
        mcnt = '0;
        step();
        RST_N = 1'b1;
        step();
        checks++;
        if (bus.state !== S_IDLE || strb !== P_NONE) begin
            failures++;
            $display("FAIL post_reset: got st=%0d s=%09b want IDLE",
                     bus.state, strb);
        end
    endtask

    // Small-counter instance: held start loops HLT so every pass retires.
    task automatic test_wrap();
        int n;
        bus2.ir    = 8'h70;
        bus2.start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            n = 0;
            while (bus2.halted !== 1'b1 && n < 30) begin
                step();
                n++;
            end
            checks++;
            if (n >= 30) begin
                failures++;
                $display("FAIL wrap_timeout k=%0d: halted=%b want 1",
                         k, bus2.halted);
            end
            checks++;
            if (bus2.instr_cnt !== 3'(k)) begin
                failures++;
                $display("FAIL wrap_cnt k=%0d: got %0d want %0d",
                         k, bus2.instr_cnt, 3'(k));
            end
            step();
            checks++;
            if (bus2.state !== S_F0 || bus2.pc_clr !== 1'b0) begin
                failures++;
                $display("FAIL held_resume k=%0d: got st=%0d clr=%b want st=2 clr=0",
                         k, bus2.state, bus2.pc_clr);
            end
        end
        bus2.start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_directed();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cpu_control_sequencer.md
Name: cpu_control_sequencer

Overview:
- Timing and control unit for the 8-bit accumulator CPU with 16x8 synchronous memory.
- Replaces the free-running SC case logic with an explicit FSM.
- Takes the registered IR and issues one-cycle load/increment/read/write/ALU strobes to the PC, AR, IR, AC, memory and ALU.
- Instruction format: IR[7]=I (indirect), IR[6:4]=opcode, IR[3:0]=address.

Parameters:
- ADDR_W, 4, address width (AR, PC, IR address field).
- DATA_W, 8, data/instruction width.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- start  in  1  run request; sampled only in IDLE and HALT.
- ir  in  DATA_W  registered instruction from IR; stable from the cycle after ir_ld.
- pc_clr  out  1  PC <= 0.
- pc_inc  out  1  PC <= PC+1.
- ar_ld_pc  out  1  AR <= PC.
- ar_ld_ir  out  1  AR <= IR[3:0].
- ar_ld_dr  out  1  AR <= DR[3:0].
- ir_ld  out  1  IR <= DR.
- mem_rd  out  1  memory captures M[AR] into DR at this edge; DR valid next cycle.
- mem_wr  out  1  M[AR] <= AC at this edge.
- alu_en  out  1  ALU evaluates alu_op.
- alu_op  out  3  equals ir[6:4] when alu_en=1, else 0.
- ac_ld  out  1  AC loads.
- ac_src  out  1  0 = AC from ALU result, 1 = AC from DR (LDA).
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.
- state  out  4  current state encoding, for debug.
- instr_cnt  out  CNT_W  count of retired instructions.

Behaviour:
- Opcodes: 000 ADD, 001 SUB, 010 XOR, 011 SHL (AC+AC), 100 LDA, 101 STA, 110 CMA, 111 HLT.
- Memory-type opcodes: 000, 001, 010, 100, 101. Register-type opcodes: 011, 110, 111; I is ignored for these.
- State encodings: IDLE=0, CLR=1, F0=2, F1=3, F2=4, DEC=5, IND0=6, IND1=7, E0=8, E1=9, HALT=10.
- Outputs are Moore-decoded from state plus ir. Any strobe not listed for a state is 0.
- At most one AR load source is active in any cycle.
- IDLE: no strobes. start=1 -> CLR, else stay.
- CLR: pc_clr -> F0.
- F0: ar_ld_pc -> F1.
- F1: mem_rd, pc_inc -> F2.
- F2: ir_ld -> DEC.
- DEC: ar_ld_ir.
  - Opcode 111 -> HALT.
  - I=1 and memory-type -> IND0.
  - Otherwise -> E0.
- IND0: mem_rd -> IND1.
- IND1: ar_ld_dr -> E0.
- E0:
  - ADD/SUB/XOR/LDA: mem_rd -> E1.
  - STA: mem_wr -> F0 (retire).
  - SHL/CMA: alu_en, ac_ld, ac_src=0 -> F0 (retire).
- E1:
  - ADD/SUB/XOR: alu_en, ac_ld, ac_src=0.
  - LDA: ac_ld, ac_src=1.
  - Then -> F0 (retire).
- HALT: halted=1. start=1 -> F0 (resume without clearing PC), else stay.
- Retire: instr_cnt increments by 1 on every transition into F0 from E0/E1, and on DEC->HALT. Wraps 2^CNT_W-1 -> 0.
- Instruction latency in cycles, F0 through the last cycle:
  - direct ADD/SUB/XOR/LDA: 6
  - indirect ADD/SUB/XOR/LDA: 8
  - STA: 5 direct, 7 indirect
  - SHL/CMA: 5
  - HLT: 4, then HALT
- start is ignored while busy=1. A held start in HALT resumes every time HALT is entered.
- Reset:
  - RST_N=0 at any time, including mid-instruction, forces state=IDLE, all strobes 0, busy=0, halted=0, instr_cnt=0 immediately (asynchronous).
  - Release is synchronous to the next CLK edge.
  - An in-flight mem_wr is aborted. Memory contents are not the controller's concern.
- No illegal states reachable. Unused encodings 11-15 -> IDLE on the next edge with all strobes 0.

Test Plan:
- Reset then start=1 for 1 cycle -> state sequence 0,1,2,3,4,5. pc_clr high exactly in CLR. busy=1 from CLR onward.
- ir=0x03 (direct ADD) -> DEC has ar_ld_ir. E0 has mem_rd. E1 has alu_en, alu_op=000, ac_ld, ac_src=0. F0 reached 6 cycles after the previous F0. instr_cnt=1.
- ir=0x85 (indirect ADD) -> IND0 mem_rd, IND1 ar_ld_dr, then E0/E1 as above. 8 cycles total.
- ir=0x52 (STA) -> single mem_wr in E0, no ac_ld. ir=0x60 (CMA) with I=1 (0xE0) -> no IND states, alu_op=110. 5 cycles each.
- ir=0x70 (HLT) -> HALT after DEC, halted=1, busy=0, instr_cnt incremented, no pc_clr. Then start=1 -> F0 directly, PC not cleared.
- RST_N low during E1 of LDA -> all outputs 0 the same cycle, instr_cnt=0. start during busy -> no effect. Preload instr_cnt at 0xFFFF, retire one -> 0x0000.
